// File: rtl/pdc_info_queue_pkg.sv
// Shared predictor definitions: branch-kind encodings and the per-packet pdc_info layout.
// The layout is LSB first: taken, kind, npc, choice, bh, pdch, tage_pdch.
package pdc_info_queue_pkg;

  localparam int BH_WIDTH_DEFAULT = 14;

  localparam logic [2:0] NOT_JUMP      = 3'd0;
  localparam logic [2:0] DIRECT_JUMP   = 3'd1;
  localparam logic [2:0] RET           = 3'd4;
  localparam logic [2:0] INDIRECT_JUMP = 3'd5;
  localparam logic [2:0] CALL          = 3'd6;
  localparam logic [2:0] JUMP          = 3'd7;

  // Everything except the history snapshot: 1+3+30+2+8+12.
  localparam int PDC_INFO_FIXED_W = 56;
  localparam int PDC_INFO_W       = PDC_INFO_FIXED_W + BH_WIDTH_DEFAULT;

  typedef struct packed {
    logic [11:0]                 tage_pdch;
    logic [7:0]                  pdch;
    logic [BH_WIDTH_DEFAULT-1:0] bh;
    logic [1:0]                  choice;
    logic [29:0]                 npc;
    logic [2:0]                  kind;
    logic                        taken;
  } pdc_info_t;

  function automatic int pdc_info_width(input int bh_width);
    return PDC_INFO_FIXED_W + bh_width;
  endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Pointer/occupancy tracker for a DEPTH-entry FIFO; push and pop act at the posedge.
// Refuses push when full and pop when empty; flush rewinds both pointers; overflow is sticky until reset.
module sync_fifo_ptr #(
  parameter int  DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push_req,
  input  logic             pop_req,
  output logic             push,
  output logic             pop,
  output logic [PTR_W-1:0] wr_idx,
  output logic [PTR_W-1:0] rd_idx,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count,
  output logic             overflow
);

  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic [PTR_W:0] wr_ptr_nxt;
  logic [PTR_W:0] rd_ptr_nxt;

  assign wr_idx = wr_ptr[PTR_W-1:0];
  assign rd_idx = rd_ptr[PTR_W-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);

  // Flush wins over any push/pop presented in the same cycle.
  assign push = push_req & ~full & ~flush;
  assign pop  = pop_req & ~empty & ~flush;

  assign wr_ptr_nxt = flush ? '0 : wr_ptr + {{PTR_W{1'b0}}, push};
  assign rd_ptr_nxt = flush ? '0 : rd_ptr + {{PTR_W{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= wr_ptr_nxt - rd_ptr_nxt;
      if (push_req && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pdc_info_queue.sv
// Holds fetch-time predictor results per packet until execute; entry pushed in cycle N is at rd_* in N+1.
// wr_ready drops when full (a push then sets overflow); stall holds the head; flush empties the queue.
module pdc_info_queue
  import pdc_info_queue_pkg::*;
#(
  parameter int  DEPTH    = 8,
  parameter int  bh_width = BH_WIDTH_DEFAULT,
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic                wr_en,
  output logic                wr_ready,
  input  logic                wr_taken_pdc,
  input  logic [2:0]          wr_kind_pdc,
  input  logic [29:0]         wr_npc_pdc,
  input  logic [1:0]          wr_choice_pdc,
  input  logic [bh_width-1:0] wr_bh_pdc,
  input  logic [7:0]          wr_pdch,
  input  logic [11:0]         wr_tage_pdch,
  input  logic                rd_en,
  input  logic                stall,
  output logic                rd_valid,
  output logic                rd_taken_pdc,
  output logic [2:0]          rd_kind_pdc,
  output logic [29:0]         rd_npc_pdc,
  output logic [1:0]          rd_choice_pdc,
  output logic [bh_width-1:0] rd_bh_pdc,
  output logic [7:0]          rd_pdch,
  output logic [11:0]         rd_tage_pdch,
  output logic [PTR_W:0]      count,
  output logic                overflow
);

  localparam int ENTRY_W = pdc_info_width(bh_width);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] rd_data;
  logic               push;
  logic               pop;
  logic [PTR_W-1:0]   wr_idx;
  logic [PTR_W-1:0]   rd_idx;
  logic               empty;
  logic               full;

  sync_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .push_req (wr_en),
    .pop_req  (rd_en & ~stall),
    .push     (push),
    .pop      (pop),
    .wr_idx   (wr_idx),
    .rd_idx   (rd_idx),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  assign wr_data = {wr_tage_pdch, wr_pdch, wr_bh_pdc, wr_choice_pdc,
                    wr_npc_pdc, wr_kind_pdc, wr_taken_pdc};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Head is read straight from storage; an empty queue presents all-zero fields.
  assign rd_data  = empty ? '0 : mem[rd_idx];
  assign rd_valid = ~empty;
  assign wr_ready = ~full;

  assign {rd_tage_pdch, rd_pdch, rd_bh_pdc, rd_choice_pdc,
          rd_npc_pdc, rd_kind_pdc, rd_taken_pdc} = rd_data;

endmodule

// File: doc/pdc_info_queue.md
Name: pdc_info_queue

Overview:
- Writer-side FIFO that captures per-packet predictor results at fetch time and holds them until the matching packet reaches execute.
- Its read side supplies the *_pdc fields consumed by the execute-stage branch result buffer, which compares them with execute results to build predictor updates.
- Sits between the predictor output and the EX-stage update path. One entry per fetch packet of 1 or 2 instructions.
- The whole queue is discarded on a pipeline redirect.

Parameters:
DEPTH, 8, number of packet entries; power of two, at least 2
bh_width, 14, branch-history snapshot width
PTR_W, $clog2(DEPTH), index width; derived, not overridden

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
flush  in  1  redirect; discard all entries
wr_en  in  1  push one packet
wr_ready  out  1  queue not full
wr_taken_pdc  in  1  predicted taken
wr_kind_pdc  in  3  predicted branch kind (NOT_JUMP=0, DIRECT_JUMP=1, RET=4, INDIRECT_JUMP=5, CALL=6, JUMP=7)
wr_npc_pdc  in  30  predicted next PC[31:2]
wr_choice_pdc  in  2  selected sub-predictor
wr_bh_pdc  in  bh_width  history snapshot
wr_pdch  in  8  base-predictor hash
wr_tage_pdch  in  12  TAGE hash
rd_en  in  1  EX consumed head packet
stall  in  1  EX stalled; rd_en ignored
rd_valid  out  1  head entry valid
rd_taken_pdc  out  1  head field
rd_kind_pdc  out  3  head field
rd_npc_pdc  out  30  head field
rd_choice_pdc  out  2  head field
rd_bh_pdc  out  bh_width  head field
rd_pdch  out  8  head field
rd_tage_pdch  out  12  head field
count  out  PTR_W+1  occupied entries
overflow  out  1  sticky: push attempted while full

Behaviour:
- Storage: DEPTH entries, each 56+bh_width bits. Field order, LSB first: taken, kind, npc, choice, bh, pdch, tage_pdch.
- Pointers: wr_ptr and rd_ptr, each PTR_W+1 bits, wrapping modulo 2*DEPTH. Entry index = ptr[PTR_W-1:0].
- Empty/full: empty when the pointers are equal. Full when the index bits are equal and the MSBs differ.
- Reset (rstn=0 at posedge): both pointers 0, count 0, overflow 0, all storage 0. As a result, rd_valid=0, rd_* outputs 0 and wr_ready=1.
- Effective push = wr_en & !full. Effective pop = rd_en & !stall & !empty.
- Push and pop take effect at the posedge. The entry written at cycle N is visible at rd_* in cycle N+1.
- Reads are combinational from storage[rd_ptr]. There is no write-to-read bypass in the same cycle.
- When empty: rd_valid=0 and all rd_* are forced to 0.
- Empty with wr_en and rd_en together: push happens, pop is ignored, count becomes 1.
- Full with wr_en and rd_en together: pop happens. Push is refused because wr_ready=0 was already low, and overflow is set. count becomes DEPTH-1.
- Otherwise, simultaneous push and pop: both pointers advance and count is unchanged.
- flush has priority over push and pop in the same cycle. Both pointers go to 0 and count to 0; storage is not cleared. overflow is not cleared by flush, only by reset.
- Reset asserted mid-stream behaves like reset: prior contents are lost.
- count = wr_ptr - rd_ptr, modulo 2*DEPTH, registered alongside the pointers.
- wr_ready = !full, combinational from the registered pointers.

Decomposition:
- Shared predictor package holds:
  - branch-kind constants NOT_JUMP/DIRECT_JUMP/RET/INDIRECT_JUMP/CALL/JUMP;
  - the packed pdc_info field layout and its width localparam (56+bh_width);
  - the default bh_width.
- One natural sub-module: sync_fifo_ptr, holding pointer, full, empty and count logic, parameterised by DEPTH. Storage and field pack/unpack stay in pdc_info_queue.

Test Plan:
- Reset then idle 3 cycles -> rd_valid=0, count=0, wr_ready=1, all rd_*=0, overflow=0.
- Push A (taken=1, kind=6, npc=30'h0000_1234, tage_pdch=12'hABC) at cycle 0 -> cycle 1: rd_valid=1 and rd_npc_pdc=30'h1234, rd_kind_pdc=6. Pop at cycle 1 -> cycle 2: rd_valid=0.
- Push 8 distinct entries (npc=1..8) -> count=8, wr_ready=0. A 9th push sets overflow=1 and is dropped. Popping 8 times returns npc 1..8 in order.
- Fill to 8, then push+pop in the same cycle -> head advances to npc=2, count=7, overflow=1. With count=3, push+pop together -> count stays 3.
- Wrap test: 20 cycles of steady push+pop with incrementing npc -> output order is preserved across the pointer wrap, with no gaps.
- With 5 entries held, assert flush with wr_en=1 and rd_en=1 -> next cycle count=0, rd_valid=0. A following push of npc=30'h77 appears at rd_npc_pdc one cycle later.
- With stall=1 and rd_en=1 and count=2 -> head is unchanged and count stays 2.
